// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-expansion controller.
package aes_pkg;

    typedef logic [127:0] key_t;
    typedef logic [3:0]   round_idx_t;

    localparam int NUM_ROUNDS = 10;
    localparam int NUM_KEYS   = 11;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

endpackage

// File: rtl/key_expansion_ctrl_round_key.sv
// roundKey: one combinational AES-128 key-schedule step (round key count -> count+1).
module roundKey (
    input  logic [127:0] inputKey,
    input  logic [3:0]   count,
    output logic [127:0] outputRoundKey
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    logic [7:0]  rcon;
    logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

    always_comb begin
        case (count)
            4'd0:    rcon = 8'h01;
            4'd1:    rcon = 8'h02;
            4'd2:    rcon = 8'h04;
            4'd3:    rcon = 8'h08;
            4'd4:    rcon = 8'h10;
            4'd5:    rcon = 8'h20;
            4'd6:    rcon = 8'h40;
            4'd7:    rcon = 8'h80;
            4'd8:    rcon = 8'h1b;
            4'd9:    rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    always_comb begin
        {w0, w1, w2, w3} = inputKey;
        // RotWord, SubWord, then fold in the round constant
        t  = sub_word({w3[23:0], w3[31:24]}) ^ {rcon, 24'h0};
        n0 = w0 ^ t;
        n1 = w1 ^ n0;
        n2 = w2 ^ n1;
        n3 = w3 ^ n2;
        outputRoundKey = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/key_expansion_ctrl.sv
// AES-128 key-expansion sequencer with 11-entry round-key store and registered read port.
// Optional KEY_EXP_PIPE_EN: registers the roundKey output, two cycles per round.
module key_expansion_ctrl #(
    parameter int KEY_W      = 128,
    parameter int NUM_ROUNDS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    input  logic [3:0]       rd_idx,
    output logic [KEY_W-1:0] rd_key
);
    import aes_pkg::*;

    state_t           state;
    round_idx_t       round_cnt;
    round_idx_t       wr_idx;
    logic [KEY_W-1:0] cur_key;
    logic [KEY_W-1:0] step_key;
    logic [KEY_W-1:0] new_key;
    logic             advance;
    logic [KEY_W-1:0] key_mem [NUM_KEYS];

    assign wr_idx = round_cnt + round_idx_t'(1);

    roundKey u_round_key (
        .inputKey       (cur_key),
        .count          (round_cnt),
        .outputRoundKey (step_key)
    );

`ifdef KEY_EXP_PIPE_EN
    logic [KEY_W-1:0] pipe_key;
    logic             store_phase;

    // Phase 0 captures the step result, phase 1 commits it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_key    <= '0;
            store_phase <= 1'b0;
        end else if (state == EXPAND) begin
            pipe_key    <= step_key;
            store_phase <= ~store_phase;
        end else begin
            store_phase <= 1'b0;
        end
    end

    assign new_key = pipe_key;
    assign advance = store_phase;
`else
    assign new_key = step_key;
    assign advance = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            keys_valid <= 1'b0;
            rd_key     <= '0;
            round_cnt  <= '0;
            cur_key    <= '0;
            for (int unsigned i = 0; i < NUM_KEYS; i++) key_mem[i] <= '0;
        end else begin
            done   <= 1'b0;
            rd_key <= (rd_idx < round_idx_t'(NUM_KEYS)) ? key_mem[rd_idx] : '0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        key_mem[0] <= key_in;
                        cur_key    <= key_in;
                        round_cnt  <= '0;
                        keys_valid <= 1'b0;
                        busy       <= 1'b1;
                        state      <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (advance) begin
                        key_mem[wr_idx] <= new_key;
                        cur_key         <= new_key;
                        if (round_cnt == round_idx_t'(NUM_ROUNDS - 1)) begin
                            state      <= DONE;
                            busy       <= 1'b0;
                            keys_valid <= 1'b1;
                            done       <= 1'b1;
                            round_cnt  <= '0;
                        end else begin
                            round_cnt <= wr_idx;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expansion_ctrl.sv
// Self-checking bench for key_expansion_ctrl against an arithmetic AES-128 key-schedule model.
module tb_key_expansion_ctrl;

`ifdef KEY_EXP_PIPE_EN
    localparam int LAT = 20;
`else
    localparam int LAT = 10;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy, done, keys_valid;
    logic [3:0]   rd_idx;
    logic [127:0] rd_key;

    int unsigned  tests = 0;
    int unsigned  fails = 0;
    logic [7:0]   sbox_m [256];
    logic [127:0] model_keys [11];

    localparam logic [127:0] KEY_A = 128'h2B6BAAB2B3768EA3F69807D892BEB46D;

    key_expansion_ctrl #(.KEY_W(128), .NUM_ROUNDS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .key_in     (key_in),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid),
        .rd_idx     (rd_idx),
        .rd_key     (rd_key)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_m[x] = s;
        end
    endtask

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Start an expansion; optionally pulse start again with k2 at cycle 4 of EXPAND.
    task automatic run_expand(input string tag, input logic [127:0] k,
                              input bit inject, input logic [127:0] k2);
        int done_at;
        int pulses;
        key_in = k;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        check({tag, "_busy_e0"}, 128'(busy), 128'(1));
        check({tag, "_kv_e0"}, 128'(keys_valid), 128'(0));
        done_at = -1;
        pulses  = 0;
        for (int c = 1; c <= LAT + 4; c++) begin
            start = inject && (c == 4);
            if (inject) key_in = k2;
            tick();
            start = 1'b0;
            if (done) begin
                pulses++;
                if (done_at < 0) done_at = c;
            end
        end
        check({tag, "_done_lat"}, 128'(done_at), 128'(LAT));
        check({tag, "_done_pulses"}, 128'(pulses), 128'(1));
        check({tag, "_kv_end"}, 128'(keys_valid), 128'(1));
        check({tag, "_busy_end"}, 128'(busy), 128'(0));
    endtask

    task automatic sweep(input string tag, input logic [127:0] k);
        model_expand(k);
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i);
            tick();
            check($sformatf("%s_rk%0d", tag, i), rd_key, (i < 11) ? model_keys[i] : 128'h0);
        end
    endtask

    task automatic read_at(input logic [3:0] idx, output logic [127:0] v);
        rd_idx = idx;
        tick();
        v = rd_key;
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] rk;
        int           dn;

        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        rd_idx = '0;
        build_sbox();
        repeat (3) tick();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_kv", 128'(keys_valid), 128'(0));
        check("rst_rdkey", rd_key, 128'h0);
        rst = 1'b0;
        tick();

        // Basic expansion and known vectors
        run_expand("basic", KEY_A, 1'b0, '0);
        read_at(4'd1, v);  check("basic_vec1", v, 128'h84E696FD3790185EC1081F8653B6ABEB);
        read_at(4'd2, v);  check("basic_vec2", v, 128'hC8847F10FF14674E3E1C78C86DAAD323);
        read_at(4'd10, v); check("basic_vec10", v, 128'hBCEF278A0CD20717E31D4D193E5BB30D);
        read_at(4'd0, v);  check("basic_vec0", v, KEY_A);
        read_at(4'd4, v);  check("basic_vec4", v, 128'h61C8FE67FE3EC0055FD486AF93941326);
        read_at(4'd9, v);  check("basic_vec9", v, 128'hD054DD4BB03D209DEFCF4A0EDD46FE14);
        read_at(4'd12, v); check("basic_vec12", v, 128'h0);
        sweep("basic", KEY_A);

        // Restart from DONE with a second start inside EXPAND that must be ignored
        run_expand("ignore", KEY_A, 1'b1, {$urandom, $urandom, $urandom, $urandom});
        read_at(4'd10, v); check("ignore_vec10", v, 128'hBCEF278A0CD20717E31D4D193E5BB30D);
        read_at(4'd0, v);  check("ignore_vec0", v, KEY_A);

        // Restart from DONE with the all-zero key
        run_expand("zero", 128'h0, 1'b0, '0);
        read_at(4'd1, v); check("zero_vec1", v, 128'h62636363626363636263636362636363);
        sweep("zero", 128'h0);

        // Random keys against the model
        for (int n = 0; n < 4; n++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            run_expand($sformatf("rand%0d", n), rk, 1'b0, '0);
            sweep($sformatf("rand%0d", n), rk);
        end

        // Asynchronous reset in the middle of an expansion
        rk = {$urandom, $urandom, $urandom, $urandom};
        key_in = rk;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        #1;
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_done", 128'(done), 128'(0));
        check("mid_rst_kv", 128'(keys_valid), 128'(0));
        check("mid_rst_rdkey", rd_key, 128'h0);
        tick();
        rst = 1'b0;
        dn = 0;
        for (int c = 0; c < LAT + 4; c++) begin
            tick();
            if (done) dn++;
        end
        check("mid_rst_no_done", 128'(dn), 128'(0));
        check("mid_rst_kv_after", 128'(keys_valid), 128'(0));
        read_at(4'd0, v); check("mid_rst_mem0", v, 128'h0);
        rk = {$urandom, $urandom, $urandom, $urandom};
        run_expand("post_rst", rk, 1'b0, '0);
        sweep("post_rst", rk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
